morse_decoder: RTL and testbench

- Receive end of the board's Morse flasher link.
- Samples a serial on/off Morse line at the unit rate, measures mark and space run lengths, and classifies each mark as dot or dash.
- Maps each completed symbol sequence back to the 3-bit letter code: 000 = S … 111 = Z.
- Pairs with the LED encoder: its output, or a photodetector watching it, drives morse_in, and the decoded letter goes to switches/HEX logic.

---
 rtl/morse_decoder.sv | 148 ++++++++++++++
 tb/tb_morse_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - Morse line receiver decoding S..Z letter codes; optional MORSE_DECODER_TOLERANT_EN widens dash timing
module morse_decoder #(
    parameter int TICK_DIV  = 25000000,
    parameter int GAP_UNITS = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       morse_in,
    output logic [2:0] letter,
    output logic       valid,
    output logic       error,
    output logic       busy,
    output logic [7:0] letter_count
);

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

    localparam logic [26:0] RELOAD = 27'(TICK_DIV - 1);
    localparam logic [3:0]  GAP    = 4'(GAP_UNITS);

    state_t      state;
    logic [26:0] tick_cnt;
    logic        tick;
    logic [1:0]  sync;
    logic        sync_in;
    logic [2:0]  run_cnt;
    logic [3:0]  run_next;
    logic [3:0]  sym_bits;
    logic [2:0]  sym_cnt;
    logic        bad;
    logic        sym_ok;
    logic        sym_dash;
    logic        lut_hit;
    logic [2:0]  lut_code;

    assign tick     = (tick_cnt == 27'd0);
    assign sync_in  = sync[1];
    assign run_next = {1'b0, run_cnt} + 4'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt <= 27'd0;
            sync     <= 2'b00;
        end else begin
            tick_cnt <= tick ? RELOAD : tick_cnt - 27'd1;
            sync     <= {sync[0], morse_in};
        end
    end

    // Mark length classification; run_cnt is always >= 1 while in MARK
    always_comb begin
        sym_ok   = 1'b0;
        sym_dash = 1'b0;
`ifdef MORSE_DECODER_TOLERANT_EN
        sym_ok   = (run_cnt >= 3'd1) && (run_cnt <= 3'd4);
        sym_dash = (run_cnt >= 3'd2);
`else
        sym_ok   = (run_cnt == 3'd1) || (run_cnt == 3'd3);
        sym_dash = (run_cnt == 3'd3);
`endif
    end

    // First symbol sits in the most significant occupied bit
    always_comb begin
        lut_hit  = 1'b1;
        lut_code = 3'd0;
        case ({sym_cnt, sym_bits})
            {3'd3, 4'b0000}: lut_code = 3'd0;
            {3'd1, 4'b0001}: lut_code = 3'd1;
            {3'd3, 4'b0001}: lut_code = 3'd2;
            {3'd4, 4'b0001}: lut_code = 3'd3;
            {3'd3, 4'b0011}: lut_code = 3'd4;
            {3'd4, 4'b1001}: lut_code = 3'd5;
            {3'd4, 4'b1011}: lut_code = 3'd6;
            {3'd4, 4'b1100}: lut_code = 3'd7;
            default:         lut_hit  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            run_cnt      <= 3'd0;
            sym_bits     <= 4'd0;
            sym_cnt      <= 3'd0;
            bad          <= 1'b0;
            letter       <= 3'd0;
            valid        <= 1'b0;
            error        <= 1'b0;
            busy         <= 1'b0;
            letter_count <= 8'd0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (sync_in) begin
                            state    <= MARK;
                            busy     <= 1'b1;
                            run_cnt  <= 3'd1;
                            sym_bits <= 4'd0;
                            sym_cnt  <= 3'd0;
                            bad      <= 1'b0;
                        end
                    end
                    MARK: begin
                        if (sync_in) begin
                            if (run_cnt != 3'd7)
                                run_cnt <= run_cnt + 3'd1;
                        end else begin
                            bad <= bad | ~sym_ok | (sym_cnt == 3'd4);
                            if (sym_cnt != 3'd4) begin
                                sym_bits <= {sym_bits[2:0], sym_dash};
                                sym_cnt  <= sym_cnt + 3'd1;
                            end
                            state   <= SPACE;
                            run_cnt <= 3'd1;
                        end
                    end
                    SPACE: begin
                        if (sync_in) begin
                            state   <= MARK;
                            run_cnt <= 3'd1;
                        end else if (run_next >= GAP) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (lut_hit && !bad) begin
                                letter       <= lut_code;
                                valid        <= 1'b1;
                                letter_count <= letter_count + 8'd1;
                            end else begin
                                error <= 1'b1;
                            end
                        end else begin
                            run_cnt <= run_next[2:0];
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - scoreboard bench for morse_decoder with a symbol-string reference model
module tb_morse_decoder;
    localparam int TICK_DIV  = 4;
    localparam int GAP_UNITS = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       morse_in = 1'b0;
    logic [2:0] letter;
    logic       valid;
    logic       error;
    logic       busy;
    logic [7:0] letter_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       err;
        logic [2:0] letter;
        logic [7:0] count;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic       prev_pulse = 1'b0;
    logic [2:0] m_letter = 3'd0;
    logic [7:0] m_count = 8'd0;
    int         mk[$];
    string      codes[8] = '{"...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    always #5 clk = ~clk;

    morse_decoder #(.TICK_DIV(TICK_DIV), .GAP_UNITS(GAP_UNITS)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .morse_in(morse_in),
        .letter(letter),
        .valid(valid),
        .error(error),
        .busy(busy),
        .letter_count(letter_count)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: turn mark lengths into a dot/dash string and look it up by name
    task automatic push_expected();
        string s;
        bit    bad;
        exp_t  e;
        s   = "";
        bad = (mk.size() > 4);
        foreach (mk[i]) begin
            if (mk[i] == 1) s = {s, "."};
`ifdef MORSE_DECODER_TOLERANT_EN
            else if (mk[i] >= 2 && mk[i] <= 4) s = {s, "-"};
`else
            else if (mk[i] == 3) s = {s, "-"};
`endif
            else bad = 1'b1;
        end
        e.err = 1'b1;
        if (!bad) begin
            for (int k = 0; k < 8; k++) begin
                if (s == codes[k]) begin
                    e.err    = 1'b0;
                    m_letter = 3'(k);
                    m_count  = m_count + 8'd1;
                end
            end
        end
        e.letter = m_letter;
        e.count  = m_count;
        exp_q.push_back(e);
    endtask

    task automatic load_code(input string c);
        mk.delete();
        for (int i = 0; i < c.len(); i++)
            mk.push_back((c.getc(i) == 8'h2D) ? 3 : 1);
    endtask

    // One Morse unit: starts just after a tick edge, ends just after the next tick edge
    task automatic unit(input logic b, input bit rst = 1'b0);
        morse_in = b;
        @(posedge clk);
        @(posedge clk);
        #1;
        if (rst) reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_letter(input int max_sp);
        push_expected();
        foreach (mk[i]) begin
            for (int j = 0; j < mk[i]; j++) begin
                unit(1'b1);
                if (i == 0 && j == 0) check("busy_start", 32'(busy), 32'd1);
            end
            if (i != mk.size() - 1)
                repeat ($urandom_range(1, max_sp)) unit(1'b0);
        end
        repeat (GAP_UNITS) unit(1'b0);
        check("busy_end", 32'(busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset_n && (valid || error)) begin
            checks++;
            if (prev_pulse) begin
                errors++;
                $display("FAIL pulse_width: valid=%0b error=%0b high on consecutive cycles, expected single-cycle pulse", valid, error);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b error=%0b letter=%0d, expected no pulse", valid, error, letter);
            end else begin
                mon_e = exp_q.pop_front();
                if ({error, valid, letter, letter_count} !== {mon_e.err, ~mon_e.err, mon_e.letter, mon_e.count}) begin
                    errors++;
                    $display("FAIL emit: got error=%0b valid=%0b letter=%0d count=%0d expected error=%0b valid=%0b letter=%0d count=%0d",
                             error, valid, letter, letter_count, mon_e.err, ~mon_e.err, mon_e.letter, mon_e.count);
                end
            end
        end
        prev_pulse = reset_n && (valid || error);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_letter", 32'(letter), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(letter_count), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        load_code("...");
        send_letter(1);
        check("s_letter", 32'(letter), 32'd0);
        check("s_count", 32'(letter_count), 32'd1);

        load_code("-..-");
        send_letter(1);
        check("x_letter", 32'(letter), 32'd5);
        load_code("--..");
        send_letter(1);
        check("z_letter", 32'(letter), 32'd7);
        check("xz_count", 32'(letter_count), 32'd3);

        mk.delete();
        mk.push_back(2);
        send_letter(1);
        check("mark2_letter", 32'(letter), 32'(m_letter));

        mk.delete();
        repeat (5) mk.push_back(1);
        send_letter(1);
        check("overflow_count", 32'(letter_count), 32'(m_count));

        unit(1'b1);
        unit(1'b0);
        unit(1'b1);
        unit(1'b0);
        unit(1'b1, 1'b1);
        m_letter = 3'd0;
        m_count  = 8'd0;
        repeat (4) unit(1'b0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_count", 32'(letter_count), 32'd0);
        load_code("...-");
        send_letter(1);
        check("v_letter", 32'(letter), 32'd3);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                load_code(codes[$urandom_range(0, 7)]);
            end else begin
                mk.delete();
                repeat ($urandom_range(1, 5))
                    mk.push_back(($urandom_range(0, 5) == 0) ? 9 : int'($urandom_range(1, 5)));
            end
            send_letter(2);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) unit(1'b0);
        end
        check("random_count", 32'(letter_count), 32'(m_count));

        unit(1'b0, 1'b1);
        m_letter = 3'd0;
        m_count  = 8'd0;
        for (int n = 0; n < 256; n++) begin
            load_code("-");
            send_letter(1);
        end
        check("wrap_count", 32'(letter_count), 32'd0);
        check("wrap_letter", 32'(letter), 32'd1);

        repeat (8) @(posedge clk);
        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
